// File: rtl/trace_checker_pkg.sv
// Shared types and helpers for the trace checker: FSM state encoding and a
// channel-bitmap popcount used to accumulate per-sample error counts.
package trace_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } tc_state_e;

  // Widest channel bitmap the popcount helper accepts; narrower maps are zero-extended.
  localparam int unsigned MaxCh = 32;

  typedef logic [MaxCh-1:0] ch_vec_t;

  function automatic int unsigned popcount(input ch_vec_t v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MaxCh; i++) begin
      cnt = cnt + {31'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/tc_vector_mem.sv
// Expected-vector storage: one synchronous write port, asynchronous read, no reset
// so contents survive a checker reset.
module tc_vector_mem #(
  parameter int unsigned Width = 96,
  parameter int unsigned Depth = 64,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_checker.sv
// Compares sampled observation vectors against a preloaded expected trace, counting
// mismatching channels and recording the first failing vector and channel set.
module trace_checker
  import trace_checker_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ERR_W  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [ADDR_W-1:0]        load_addr,
  input  logic [NUM_CH*DATA_W-1:0] load_data,
  input  logic                     start,
  input  logic [ADDR_W:0]          num_vectors,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     sample,
  input  logic [NUM_CH*DATA_W-1:0] obs,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_W-1:0]         error_count,
  output logic [ADDR_W-1:0]        first_fail_idx,
  output logic [NUM_CH-1:0]        first_fail_ch,
  output logic                     mismatch
);

  localparam int unsigned VecW = NUM_CH * DATA_W;
  // Headroom so the unsaturated sum never wraps before the clamp.
  localparam int unsigned SumW = ERR_W + 8;
  localparam logic [ERR_W-1:0] ErrMax = '1;

  tc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] ffi_q, ffi_d;
  logic [NUM_CH-1:0] ffc_q, ffc_d;
  logic              mm_q, mm_d;

  logic [VecW-1:0]   exp_vec;
  logic [NUM_CH-1:0] fail_bits;
  logic [ADDR_W:0]   n_clamped;
  logic [SumW-1:0]   err_sum;
  logic              is_last;
  logic              mem_we;

  assign mem_we = load_en && (state_q != StRun) && !start;

  tc_vector_mem #(
    .Width (VecW),
    .Depth (DEPTH),
    .AddrW (ADDR_W)
  ) u_vector_mem (
    .clk_i   (clock),
    .we_i    (mem_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (idx_q),
    .rdata_o (exp_vec)
  );

  always_comb begin
    fail_bits = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      fail_bits[c] = mask_q[c] && (obs[c*DATA_W +: DATA_W] !== exp_vec[c*DATA_W +: DATA_W]);
    end
  end

  assign n_clamped = (num_vectors > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_vectors;
  assign is_last   = ({1'b0, idx_q} == (n_q - 1'b1));
  assign err_sum   = SumW'(err_q) + SumW'(popcount(ch_vec_t'(fail_bits)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    mask_d  = mask_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    ffc_d   = ffc_q;
    mm_d    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          idx_d   = '0;
          err_d   = '0;
          ffi_d   = '0;
          ffc_d   = '0;
          n_d     = n_clamped;
          mask_d  = ch_mask;
          state_d = (n_clamped == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (sample) begin
          mm_d  = |fail_bits;
          err_d = (err_sum > {8'd0, ErrMax}) ? ErrMax : err_sum[ERR_W-1:0];
          // The count never returns to zero within a run, so zero means no earlier failure.
          if ((|fail_bits) && (err_q == '0)) begin
            ffi_d = idx_q;
            ffc_d = fail_bits;
          end
          idx_d = idx_q + 1'b1;
          if (is_last) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      n_q     <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      ffc_q   <= '0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      ffc_q   <= ffc_d;
      mm_q    <= mm_d;
    end
  end

  assign busy           = (state_q == StRun);
  assign done           = (state_q == StDone);
  assign pass           = done && (err_q == '0);
  assign error_count    = err_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_ch  = ffc_q;
  assign mismatch       = mm_q;

endmodule

// File: tb/tb_trace_checker.sv
// Scoreboard bench for trace_checker: a default instance plus an ERR_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_trace_checker;

  logic        clock = 1'b0;
  logic        reset, load_en, start, sample;
  logic [5:0]  load_addr;
  logic [95:0] load_data, obs;
  logic [6:0]  num_vectors;
  logic [2:0]  ch_mask;

  logic        busy, done, pass, mismatch;
  logic [15:0] error_count;
  logic [5:0]  first_fail_idx;
  logic [2:0]  first_fail_ch;

  logic        busy_s, done_s, pass_s, mismatch_s;
  logic [1:0]  error_count_s;
  logic [5:0]  first_fail_idx_s;
  logic [2:0]  first_fail_ch_s;

  always #5 clock = ~clock;

  trace_checker dut (
    .clock (clock), .reset (reset), .load_en (load_en), .load_addr (load_addr),
    .load_data (load_data), .start (start), .num_vectors (num_vectors), .ch_mask (ch_mask),
    .sample (sample), .obs (obs), .busy (busy), .done (done), .pass (pass),
    .error_count (error_count), .first_fail_idx (first_fail_idx),
    .first_fail_ch (first_fail_ch), .mismatch (mismatch)
  );

  trace_checker #(.ERR_W(2)) dut_sat (
    .clock (clock), .reset (reset), .load_en (load_en), .load_addr (load_addr),
    .load_data (load_data), .start (start), .num_vectors (num_vectors), .ch_mask (ch_mask),
    .sample (sample), .obs (obs), .busy (busy_s), .done (done_s), .pass (pass_s),
    .error_count (error_count_s), .first_fail_idx (first_fail_idx_s),
    .first_fail_ch (first_fail_ch_s), .mismatch (mismatch_s)
  );

  typedef struct packed {
    logic        mm;
    logic [15:0] err;
    logic [1:0]  errs;
    logic [5:0]  ffi;
    logic [2:0]  ffc;
    logic        dn;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [95:0] vec [3];
  logic [95:0] m_mem [64];
  int          m_idx, m_n, m_err, m_errs;
  logic [2:0]  m_mask;
  logic [5:0]  m_ffi;
  logic [2:0]  m_ffc;
  logic        m_failed;

  localparam logic [95:0] HiCorrupt = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};

  function automatic exp_t act();
    return {mismatch, error_count, error_count_s, first_fail_idx, first_fail_ch, done};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_vec(input int a, input logic [95:0] d);
    load_en   = 1'b1;
    load_addr = 6'(a);
    load_data = d;
    tick();
    load_en   = 1'b0;
    m_mem[a]  = d;
  endtask

  task automatic start_run(input int n, input logic [2:0] mask);
    start       = 1'b1;
    num_vectors = 7'(n);
    ch_mask     = mask;
    tick();
    start    = 1'b0;
    m_idx    = 0;
    m_n      = (n > 64) ? 64 : n;
    m_mask   = mask;
    m_err    = 0;
    m_errs   = 0;
    m_ffi    = '0;
    m_ffc    = '0;
    m_failed = 1'b0;
  endtask

  // Model the expected post-sample result, queue it, then strobe the DUT.
  task automatic drive_sample(input logic [95:0] o);
    logic [2:0] bits;
    int         cnt;
    bits = '0;
    for (int c = 0; c < 3; c++) begin
      if (m_mask[c] && (o[c*32 +: 32] !== m_mem[m_idx][c*32 +: 32])) bits[c] = 1'b1;
    end
    cnt = $countones(bits);
    if (cnt != 0 && !m_failed) begin
      m_failed = 1'b1;
      m_ffi    = 6'(m_idx);
      m_ffc    = bits;
    end
    m_err  = (m_err + cnt > 65535) ? 65535 : m_err + cnt;
    m_errs = (m_errs + cnt > 3) ? 3 : m_errs + cnt;
    m_idx++;
    exp_q.push_back('{mm: (cnt != 0), err: 16'(m_err), errs: 2'(m_errs), ffi: m_ffi,
                      ffc: m_ffc, dn: (m_idx == m_n)});
    sample = 1'b1;
    obs    = o;
    tick();
    sample = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, done, pass, mismatch, error_count, first_fail_idx, first_fail_ch} !== '0)
      $display("FAIL reset_outputs: got %h want 0",
               {busy, done, pass, mismatch, error_count, first_fail_idx, first_fail_ch});
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if ({busy, done, pass} !== 3'b000)
      $display("FAIL reset_idle_hold: got %b want 000", {busy, done, pass});
    else n_pass++;
  endtask

  task automatic test_all_match();
    for (int i = 0; i < 3; i++) load_vec(i, vec[i]);
    start_run(3, 3'b111);
    n_checks++;
    if ({busy, done} !== 2'b10) $display("FAIL match_busy: got %b want 10", {busy, done});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive_sample(vec[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (act() !== e) $display("FAIL match_sample%0d: got %h want %h", i, act(), e);
      else n_pass++;
    end
    n_checks++;
    if ({busy, done, pass} !== 3'b011)
      $display("FAIL match_pass: got %b want 011", {busy, done, pass});
    else n_pass++;
  endtask

  task automatic test_mismatch();
    logic [95:0] o;
    start_run(3, 3'b111);
    for (int i = 0; i < 3; i++) begin
      o = (i == 1) ? {32'd4, 32'd1, vec[1][31:0]} : vec[i];
      drive_sample(o);
      e = exp_q.pop_front();
      n_checks++;
      if (act() !== e) $display("FAIL mismatch_sample%0d: got %h want %h", i, act(), e);
      else n_pass++;
    end
    n_checks++;
    if ({error_count, first_fail_idx, first_fail_ch, pass} !== {16'd2, 6'd1, 3'b110, 1'b0})
      $display("FAIL mismatch_final: got %h want %h",
               {error_count, first_fail_idx, first_fail_ch, pass},
               {16'd2, 6'd1, 3'b110, 1'b0});
    else n_pass++;
  endtask

  task automatic test_mask();
    start_run(3, 3'b001);
    for (int i = 0; i < 3; i++) begin
      drive_sample(vec[i] ^ HiCorrupt);
      e = exp_q.pop_front();
      n_checks++;
      if (act() !== e) $display("FAIL mask_sample%0d: got %h want %h", i, act(), e);
      else n_pass++;
    end
    n_checks++;
    if ({error_count, pass} !== {16'd0, 1'b1})
      $display("FAIL mask_pass: got %h want %h", {error_count, pass}, {16'd0, 1'b1});
    else n_pass++;
  endtask

  task automatic test_saturate();
    start_run(2, 3'b111);
    for (int i = 0; i < 2; i++) begin
      drive_sample(~vec[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (act() !== e) $display("FAIL sat_sample%0d: got %h want %h", i, act(), e);
      else n_pass++;
    end
    n_checks++;
    if ({error_count_s, error_count, pass_s} !== {2'd3, 16'd6, 1'b0})
      $display("FAIL sat_count: got %h want %h", {error_count_s, error_count, pass_s},
               {2'd3, 16'd6, 1'b0});
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    start_run(3, 3'b111);
    drive_sample(vec[0] ^ 96'd1);
    e = exp_q.pop_front();
    n_checks++;
    if (act() !== e) $display("FAIL midrun_sample: got %h want %h", act(), e);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({busy, done, pass, mismatch, error_count, first_fail_idx, first_fail_ch} !== '0)
      $display("FAIL midrun_reset: got %h want 0",
               {busy, done, pass, mismatch, error_count, first_fail_idx, first_fail_ch});
    else n_pass++;
    // A strobe while idle must not touch any counter or flag.
    sample = 1'b1;
    obs    = '0;
    tick();
    sample = 1'b0;
    n_checks++;
    if ({busy, mismatch, error_count} !== '0)
      $display("FAIL idle_sample: got %h want 0", {busy, mismatch, error_count});
    else n_pass++;
    start_run(3, 3'b111);
    for (int i = 0; i < 3; i++) begin
      drive_sample(vec[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (act() !== e) $display("FAIL rerun_sample%0d: got %h want %h", i, act(), e);
      else n_pass++;
    end
    n_checks++;
    if (pass !== 1'b1) $display("FAIL rerun_pass: got %b want 1", pass);
    else n_pass++;
  endtask

  task automatic test_zero_and_collision();
    start_run(0, 3'b111);
    n_checks++;
    if ({busy, done, pass} !== 3'b011)
      $display("FAIL zero_run: got %b want 011", {busy, done, pass});
    else n_pass++;
    // Same-cycle load must be dropped in favour of start.
    load_en   = 1'b1;
    load_addr = 6'd0;
    load_data = ~vec[0];
    start_run(2, 3'b111);
    load_en = 1'b0;
    // Load and start while running must both be ignored.
    load_en     = 1'b1;
    load_addr   = 6'd1;
    load_data   = ~vec[1];
    start       = 1'b1;
    num_vectors = 7'd0;
    tick();
    load_en = 1'b0;
    start   = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b10)
      $display("FAIL run_ignores_start: got %b want 10", {busy, done});
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive_sample(vec[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (act() !== e) $display("FAIL collision_sample%0d: got %h want %h", i, act(), e);
      else n_pass++;
    end
    n_checks++;
    if ({done, pass, error_count} !== {1'b1, 1'b1, 16'd0})
      $display("FAIL collision_pass: got %h want %h", {done, pass, error_count},
               {1'b1, 1'b1, 16'd0});
    else n_pass++;
  endtask

  initial begin
    reset       = 1'b1;
    load_en     = 1'b0;
    start       = 1'b0;
    sample      = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    obs         = '0;
    num_vectors = '0;
    ch_mask     = '0;
    vec[0] = {32'd5, 32'd0, 32'h2840_0005};
    vec[1] = {32'd3, 32'd0, 32'h2880_0003};
    vec[2] = {32'd3, 32'd5, 32'h00C2_2000};

    test_reset();
    test_all_match();
    test_mismatch();
    test_mask();
    test_saturate();
    test_reset_midrun();
    test_zero_and_collision();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have parameter DATA_W, 32, width of one compared channel.
REQ-002 SHALL have parameter NUM_CH, 3, number of compared channels (e.g. opcode, operand A, operand B).
REQ-003 SHALL have parameter DEPTH, 64, number of expected-vector entries.
REQ-004 SHALL have parameter ERR_W, 16, error counter width; ADDR_W = clog2(DEPTH) is derived.
REQ-005 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port load_en  in  1  write one expected vector.
REQ-008 SHALL have port load_addr  in  ADDR_W  vector index to write.
REQ-009 SHALL have port load_data  in  NUM_CH*DATA_W  expected values, channel 0 in the LSBs.
REQ-010 SHALL have port start  in  1  begin a checking run.
REQ-011 SHALL have port num_vectors  in  ADDR_W+1  vectors in the run, sampled at start.
REQ-012 SHALL have port ch_mask  in  NUM_CH  per-channel compare enable, sampled at start.
REQ-013 SHALL have port sample  in  1  one-cycle strobe: obs is valid for the current vector.
REQ-014 SHALL have port obs  in  NUM_CH*DATA_W  observed DUT values.
REQ-015 SHALL have ports busy, done, pass (out, 1 bit each), error_count (out, ERR_W), first_fail_idx (out, ADDR_W), first_fail_ch (out, NUM_CH), and mismatch (out, 1-cycle pulse).

Function
REQ-016 SHALL implement the states IDLE, RUN and DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-017 SHALL write load_data to mem[load_addr] when load_en=1 in IDLE or DONE, and SHALL ignore load_en in RUN.
REQ-018 SHALL, on start in IDLE or DONE, clear error_count, first_fail_*, and the vector index, latch num_vectors (clamped to DEPTH) and ch_mask, and enter RUN; start has priority over a same-cycle load_en, whose write is dropped.
REQ-019 SHALL, on start with num_vectors=0, go directly to DONE with pass=1.
REQ-020 SHALL ignore start in RUN.
REQ-021 SHALL, on each sample in RUN, compare every channel c with ch_mask[c]=1 (full DATA_W, 4-state !== semantics in simulation) against mem[idx].
REQ-022 SHALL produce mismatch, error_count and first_fail_* updates exactly 1 cycle after the sample strobe.
REQ-023 SHALL add the number of mismatching channels (0..NUM_CH) to error_count per sample, saturating at 2^ERR_W-1 without wrap.
REQ-024 SHALL capture first_fail_idx=idx and first_fail_ch=bitmap on the first mismatching sample only; later mismatches leave them unchanged.
REQ-025 SHALL advance idx by 1 per sample; the sample with idx=num_vectors-1 SHALL move the block to DONE on the same edge that posts its result.
REQ-026 SHALL ignore sample outside RUN, with no counter or flag change.
REQ-027 SHALL drive pass = done & (error_count==0); pass SHALL be 0 outside DONE.

Reset
REQ-028 SHALL, under reset (including mid-run), enter IDLE with busy=0, done=0, pass=0, mismatch=0, error_count=0, first_fail_idx=0, first_fail_ch=0 and idx=0.
REQ-029 SHALL leave vector memory contents unspecified after reset and SHALL NOT clear them.

Structure
REQ-030 SHALL place the state enum and a NUM_CH popcount function in package trace_checker_pkg.
REQ-031 SHALL implement vector storage as sub-module tc_vector_mem (1 write port, asynchronous read, DEPTH x NUM_CH*DATA_W).

Verification
REQ-032 SHALL cover: load 3 vectors {0x28400005,0,5}, {0x28800003,0,3}, {0x00C22000,5,3}, start n=3, mask=3'b111, matching obs -> done=1, pass=1, error_count=0.
REQ-033 SHALL cover: same run with vector 1 obs ch2=4 and ch1=1 -> mismatch pulse 1 cycle after the 2nd sample, error_count=2, first_fail_idx=1, first_fail_ch=3'b110, pass=0.
REQ-034 SHALL cover: mask=3'b001 with ch1/ch2 corrupted on every vector -> error_count=0, pass=1.
REQ-035 SHALL cover: ERR_W=2, NUM_CH=3, all channels wrong on 2 vectors -> error_count saturates at 3.
REQ-036 SHALL cover: reset asserted after 1 of 3 samples -> next cycle IDLE, all outputs 0; a new start reruns from idx 0.
REQ-037 SHALL cover: start with n=0 -> DONE/pass=1 next cycle; load_en and start in the same cycle -> memory unchanged.
